serial_io_controller: RTL and testbench

SERIAL_IO_CONTROLLER -- requirements
Module: serial_io_controller

---
 rtl/serial_io_controller.sv | 132 +++++++++++++
 tb/tb_serial_io_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_io_controller.sv
// Byte-wide serial I/O bridge between the CPU data port and a UART: an RX FIFO read by the CPU
// and a TX FIFO drained into the transmitter by a small handshake FSM. Sticky overflow flags.
module serial_io_controller #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_rden_in,
  input  logic                  serial_wren_in,
  input  logic [7:0]            serial_wrdata_in,
  output logic [7:0]            serial_rddata_out,
  output logic                  serial_valid_out,
  output logic                  serial_ready_out,
  input  logic [7:0]            uart_rx_data_in,
  input  logic                  uart_rx_valid_in,
  output logic [7:0]            uart_tx_data_out,
  output logic                  uart_tx_valid_out,
  input  logic                  uart_tx_ready_in,
  input  logic                  status_clear_in,
  output logic                  rx_overflow_out,
  output logic                  tx_overflow_out,
  output logic [DEPTH_LOG2:0]   rx_count_out,
  output logic [DEPTH_LOG2:0]   tx_count_out
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CntOne    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  logic [7:0] rx_mem [Depth];
  logic [7:0] tx_mem [Depth];

  logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
  logic [DEPTH_LOG2:0]   rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic [7:0]            tx_data_q;
  logic                  rx_ovf_q, tx_ovf_q;
  state_e                state_q, state_d;

  logic rx_push, rx_pop, rx_drop, tx_push, tx_pop, tx_drop, tx_valid;

  // Fullness is judged on registered counts only, so a same-edge pop never makes room.
  assign rx_push = uart_rx_valid_in && (rx_count_q != FullCount);
  assign rx_drop = uart_rx_valid_in && (rx_count_q == FullCount);
  assign rx_pop  = serial_rden_in && (rx_count_q != '0);
  assign tx_push = serial_wren_in && serial_ready_out;
  assign tx_drop = serial_wren_in && !serial_ready_out;

  always_comb begin
    rx_count_d = rx_count_q;
    if (rx_push && !rx_pop) begin
      rx_count_d = rx_count_q + CntOne;
    end else if (!rx_push && rx_pop) begin
      rx_count_d = rx_count_q - CntOne;
    end
    tx_count_d = tx_count_q;
    if (tx_push && !tx_pop) begin
      tx_count_d = tx_count_q + CntOne;
    end else if (!tx_push && tx_pop) begin
      tx_count_d = tx_count_q - CntOne;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_pop   = 1'b0;
    tx_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_count_q != '0) begin
          tx_pop  = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        tx_valid = 1'b1;
        if (uart_tx_ready_in) state_d = StGap;
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset && rx_push) rx_mem[rx_wptr_q] <= uart_rx_data_in;
    if (!reset && tx_push) tx_mem[tx_wptr_q] <= serial_wrdata_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_count_q <= '0;
      tx_count_q <= '0;
      tx_data_q  <= 8'h00;
      rx_ovf_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      state_q    <= StIdle;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrOne;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrOne;
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
      if (tx_pop) begin
        tx_rptr_q <= tx_rptr_q + PtrOne;
        tx_data_q <= tx_mem[tx_rptr_q];
      end
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
      state_q    <= state_d;
      // A fresh overflow outranks a same-edge clear.
      if (rx_drop)              rx_ovf_q <= 1'b1;
      else if (status_clear_in) rx_ovf_q <= 1'b0;
      if (tx_drop)              tx_ovf_q <= 1'b1;
      else if (status_clear_in) tx_ovf_q <= 1'b0;
    end
  end

  assign serial_rddata_out = (rx_count_q != '0) ? rx_mem[rx_rptr_q] : 8'h00;
  assign serial_valid_out  = (rx_count_q != '0);
  assign serial_ready_out  = (tx_count_q != FullCount);
  assign uart_tx_data_out  = tx_data_q;
  assign uart_tx_valid_out = tx_valid;
  assign rx_overflow_out   = rx_ovf_q;
  assign tx_overflow_out   = tx_ovf_q;
  assign rx_count_out      = rx_count_q;
  assign tx_count_out      = tx_count_q;

endmodule

// File: tb/tb_serial_io_controller.sv
// Scoreboard bench for serial_io_controller: expected RX/TX bytes are queued as stimulus is
// driven and compared as the DUT presents them.
module tb_serial_io_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       serial_rden_in, serial_wren_in;
  logic [7:0] serial_wrdata_in, serial_rddata_out;
  logic       serial_valid_out, serial_ready_out;
  logic [7:0] uart_rx_data_in, uart_tx_data_out;
  logic       uart_rx_valid_in, uart_tx_valid_out, uart_tx_ready_in;
  logic       status_clear_in, rx_overflow_out, tx_overflow_out;
  logic [2:0] rx_count_out, tx_count_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  serial_io_controller #(.DEPTH_LOG2(2)) dut (
    .clock             (clock),
    .reset             (reset),
    .serial_rden_in    (serial_rden_in),
    .serial_wren_in    (serial_wren_in),
    .serial_wrdata_in  (serial_wrdata_in),
    .serial_rddata_out (serial_rddata_out),
    .serial_valid_out  (serial_valid_out),
    .serial_ready_out  (serial_ready_out),
    .uart_rx_data_in   (uart_rx_data_in),
    .uart_rx_valid_in  (uart_rx_valid_in),
    .uart_tx_data_out  (uart_tx_data_out),
    .uart_tx_valid_out (uart_tx_valid_out),
    .uart_tx_ready_in  (uart_tx_ready_in),
    .status_clear_in   (status_clear_in),
    .rx_overflow_out   (rx_overflow_out),
    .tx_overflow_out   (tx_overflow_out),
    .rx_count_out      (rx_count_out),
    .tx_count_out      (tx_count_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rx_strobe(input logic [7:0] b);
    uart_rx_data_in  = b;
    uart_rx_valid_in = 1'b1;
    if (rx_q.size() < 4) rx_q.push_back(b);
    tick();
    uart_rx_valid_in = 1'b0;
  endtask

  task automatic rx_pop();
    logic [7:0] exp;
    if (rx_q.size() > 0) begin
      exp = rx_q.pop_front();
      check("rx_head", serial_rddata_out, exp);
    end else begin
      check("rx_empty_data", serial_rddata_out, 8'h00);
    end
    serial_rden_in = 1'b1;
    tick();
    serial_rden_in = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b, input logic accept);
    serial_wrdata_in = b;
    serial_wren_in   = 1'b1;
    if (accept) tx_q.push_back(b);
    tick();
    serial_wren_in = 1'b0;
  endtask

  task automatic tx_drain();
    int last = -1;
    int cyc  = 0;
    logic [7:0] exp;
    uart_tx_ready_in = 1'b1;
    while (tx_q.size() > 0 && cyc < 60) begin
      if (uart_tx_valid_out) begin
        exp = tx_q.pop_front();
        check("tx_data", uart_tx_data_out, exp);
        if (last >= 0) check("tx_spacing", cyc - last, 3);
        last = cyc;
      end
      tick();
      cyc++;
    end
    if (tx_q.size() != 0) check("tx_drain_timeout", tx_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    serial_rden_in = 0; serial_wren_in = 0; serial_wrdata_in = 0;
    uart_rx_data_in = 0; uart_rx_valid_in = 0; uart_tx_ready_in = 0; status_clear_in = 0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", serial_valid_out, 0);
    check("rst_rddata", serial_rddata_out, 8'h00);
    check("rst_ready", serial_ready_out, 1);
    check("rst_tx_valid", uart_tx_valid_out, 0);
    check("rst_counts", {rx_count_out, tx_count_out}, 0);
    check("rst_flags", {rx_overflow_out, tx_overflow_out}, 0);

    // RX fill past full: fifth byte is dropped and flagged.
    for (int i = 1; i <= 5; i++) begin
      rx_strobe(8'(i * 17));
      if (i == 4) check("rx_no_ovf_yet", rx_overflow_out, 0);
    end
    check("rx_fill_count", rx_count_out, 4);
    check("rx_fill_head", serial_rddata_out, 8'h11);
    check("rx_fill_ovf", rx_overflow_out, 1);
    for (int i = 0; i < 4; i++) rx_pop();
    check("rx_drained_valid", serial_valid_out, 0);
    check("rx_drained_data", serial_rddata_out, 8'h00);
    status_clear_in = 1'b1; tick(); status_clear_in = 1'b0;
    check("rx_ovf_cleared", rx_overflow_out, 0);
    rx_pop();
    check("rx_pop_empty_count", rx_count_out, 0);
    check("rx_pop_empty_flag", rx_overflow_out, 0);

    // TX latency with the transmitter always ready.
    uart_tx_ready_in = 1'b1;
    tx_write(8'hA5, 1'b1);
    check("lat_e0_valid", uart_tx_valid_out, 0);
    check("lat_e0_count", tx_count_out, 1);
    tick();
    check("lat_e1_valid", uart_tx_valid_out, 1);
    check("lat_e1_data", uart_tx_data_out, tx_q.pop_front());
    check("lat_e1_count", tx_count_out, 0);
    tick();
    check("lat_gap_valid", uart_tx_valid_out, 0);
    tick();
    check("lat_idle_valid", uart_tx_valid_out, 0);

    // TX backpressure: first byte parks in SEND, four queue, sixth write overflows.
    uart_tx_ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("bp_ready", serial_ready_out, 1);
      tx_write(8'(i), 1'b1);
    end
    check("bp_full_ready", serial_ready_out, 0);
    tx_write(8'h06, 1'b0);
    check("bp_tx_ovf", tx_overflow_out, 1);
    check("bp_count", tx_count_out, 4);
    check("bp_valid", uart_tx_valid_out, 1);
    check("bp_held_data", uart_tx_data_out, 8'h01);
    tx_drain();
    tick(); tick();
    check("bp_after_count", tx_count_out, 0);
    check("bp_after_ready", serial_ready_out, 1);
    status_clear_in = 1'b1; tick(); status_clear_in = 1'b0;
    check("tx_ovf_cleared", tx_overflow_out, 0);

    // Full RX with strobe, pop and clear on the same edge.
    for (int i = 0; i < 4; i++) rx_strobe(8'hA0 + 8'(i));
    check("sim_full", rx_count_out, 4);
    check("sim_head", serial_rddata_out, rx_q.pop_front());
    uart_rx_data_in = 8'hEE; uart_rx_valid_in = 1'b1;
    serial_rden_in = 1'b1; status_clear_in = 1'b1;
    tick();
    uart_rx_valid_in = 1'b0; serial_rden_in = 1'b0; status_clear_in = 1'b0;
    check("sim_count", rx_count_out, 3);
    check("sim_ovf_wins", rx_overflow_out, 1);
    for (int i = 0; i < 3; i++) rx_pop();
    check("sim_drained", serial_valid_out, 0);

    // Reset while a byte is in flight with more queued and flags set.
    uart_tx_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) tx_write(8'h30 + 8'(i), 1'b0);
    check("mid_valid", uart_tx_valid_out, 1);
    check("mid_tx_ovf", tx_overflow_out, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    tx_q.delete(); rx_q.delete();
    check("mid_rst_valid", uart_tx_valid_out, 0);
    check("mid_rst_counts", {rx_count_out, tx_count_out}, 0);
    check("mid_rst_flags", {rx_overflow_out, tx_overflow_out}, 0);
    check("mid_rst_data", uart_tx_data_out, 8'h00);
    uart_tx_ready_in = 1'b1;
    tick(); tick();
    check("mid_post_valid", uart_tx_valid_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
